multiply_tokens: RTL and testbench
==================================

# multiply_tokens

Serial token expander: each '1' accepted on input `a` is replayed as `FACTOR` '1' tokens on output `b`, one token per cycle at most. It is the opposite of the token-halving stage. Surplus tokens wait in a bounded backlog counter, and an input-side ready signal throttles the producer. It sits on the same one-bit-per-cycle token streams as the other serial blocks in the sequential exercise set.

## Interface
- `FACTOR`, default 2: number of output tokens per accepted input token; legal range 1..8.
- `DEPTH`, default 15: maximum backlog of pending output tokens; must satisfy `DEPTH >= FACTOR`.
- `clk`  input  1  single clock; all state updates on posedge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `a`  input  1  input token stream, one bit per cycle ('1' = token).
- `a_ready`  output  1  high when a token on `a` this cycle will be accepted.
- `b`  output  1  output token stream.
- `busy`  output  1  backlog non-zero.
- `overflow`  output  1  sticky; a token was dropped.
- `tokens_in`  output  16  count of accepted tokens; present only with the stats macro.
- `tokens_out`  output  16  count of emitted tokens; present only with the stats macro.

## Operation
- Pending counter `P`, width `$clog2(DEPTH+1)`. It is the only core state besides `overflow`.
- `acc = a & a_ready`.
- `b = acc | (P != 0)`: combinational, so the first copy of a token leaves in the same cycle it arrives.
- `P_next = P + (acc ? FACTOR : 0) - b`. `P` never underflows and never exceeds `DEPTH`.
- `a_ready = (P <= DEPTH - FACTOR + 1)`. This is combinational from `P` only and does not depend on `a`.
- `busy = (P != 0)`.
- States, implied by `P`:
  - IDLE when `P == 0`.
  - DRAIN when `0 < P < DEPTH-FACTOR+2`.
  - FULL when `a_ready == 0`.
- Transitions follow `P_next`. A token arriving in the last DRAIN cycle (`P == 1`) is accepted and continues the stream with no bubble.
- A token with `a == 1` while `a_ready == 0` is dropped:
  - `P` is unchanged by it.
  - `overflow` sets on the next edge and stays high until reset.
- With `FACTOR == 1`, `b == a` and `P` stays 0; the block is a pure pass-through.
- Reset values: `P = 0`, `overflow = 0`. Therefore `b` follows `a` and `a_ready = 1` during and after reset.
- Reset mid-drain discards the backlog immediately (asynchronous). No further tokens are emitted.

## Timing
- Latency from accepted token to first output token: 0 cycles. The remaining `FACTOR-1` copies appear on the following consecutive cycles, unless earlier backlog is still pending.
- Output is continuous: `b` is high every cycle while `P != 0`.
- Throughput:
  - Sustained input rate of 1 token per `FACTOR` cycles without back-pressure.
  - Denser input fills the backlog, after which `a_ready` drops.
- `a_ready` and `busy` are registered-state derived. `b` has a combinational path from `a`.
- Deassertion of `rst_n` is synchronised by the design environment; the block needs no extra reset cycles.

## Configuration
- `MULTIPLY_TOKENS_STATS_EN` defined:
  - Adds `tokens_in` and `tokens_out`, 16-bit saturating counters (stick at 16'hFFFF).
  - `tokens_in` increments on `acc` and `tokens_out` increments on `b`.
  - Both counters reset to 0 on `rst_n` low.
- `MULTIPLY_TOKENS_STATS_EN` undefined: the ports and counters do not exist. Core behaviour is identical.

## Structure
- Shared package `token_pkg` holds:
  - a `pending_w(depth)` width function;
  - the 16-bit stats counter typedef `stat_cnt_t`;
  - the `STAT_MAX` constant.
- Sub-module `sat_counter` (parameterised width, increment enable, async active-low reset) is instantiated twice under the macro.
- The core counter logic stays in `multiply_tokens`.

## Test plan
1. FACTOR=2, DEPTH=15. Drive `a` = 1,0,1,1,0,0 after reset. Expect:
   - `b` = 1,1,1,1,1,1;
   - `P` = 1,0,1,2,1,0;
   - `a_ready` high throughout.
2. FACTOR=2, DEPTH=4. Hold `a`=1 for 8 cycles. Expect:
   - `P` climbs 1,2,3,4;
   - `a_ready` low when `P==4`, then toggles;
   - `overflow` set after the first dropped token;
   - `b` stays high until `P` drains to 0.
3. FACTOR=3. Send a single token, then zeros. Expect `b` = 1,1,1,0 and `busy` = 0,1,1,0 (as seen in the cycle of each output).
4. FACTOR=1. Drive a random 64-bit `a` pattern. Expect `b == a` every cycle, `busy` never high, and `overflow` never set.
5. Reset mid-drain: FACTOR=4 with one token, then pull `rst_n` low one cycle later. Expect `b` to fall immediately, `P = 0` and `overflow = 0`, and no tokens after release.
6. With `MULTIPLY_TOKENS_STATS_EN`:
   - Scenario 1 gives `tokens_in = 3` and `tokens_out = 6`.
   - Forcing 70000 accepted tokens saturates `tokens_in` at 16'hFFFF.

Source files
------------

// File: rtl/token_pkg.sv
// Shared definitions for the serial token blocks: backlog width helper and
// the statistics counter type.
package token_pkg;

   localparam int unsigned STAT_W = 16;

   typedef logic [STAT_W-1:0] stat_cnt_t;

   localparam stat_cnt_t STAT_MAX = '1;

   // Bits needed to hold a backlog count in 0..depth.
   function automatic int unsigned pending_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones.
// Ports: clk, rst_n (async active-low), inc (count enable), count (value).
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count on inc until every bit is set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/multiply_tokens.sv
// Serial token expander: every token accepted on a is replayed as FACTOR
// consecutive tokens on b. Surplus copies wait in a bounded backlog; a_ready
// throttles the producer, and a token offered while not ready is dropped and
// latches overflow.
// Ports: clk, rst_n (async active-low), a (input tokens), a_ready (accept
// this cycle), b (output tokens, combinational from a), busy (backlog
// non-zero), overflow (sticky drop flag), tokens_in / tokens_out (16-bit
// saturating stats, only when MULTIPLY_TOKENS_STATS_EN is defined).
module multiply_tokens
   import token_pkg::*;
#(
   parameter int unsigned FACTOR = 2,
   parameter int unsigned DEPTH  = 15
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      a,
   output logic      a_ready,
   output logic      b,
   output logic      busy,
   output logic      overflow
`ifdef MULTIPLY_TOKENS_STATS_EN
   ,
   output stat_cnt_t tokens_in,
   output stat_cnt_t tokens_out
`endif
);

   localparam int unsigned PW        = pending_w(DEPTH);
   // Highest backlog at which a new token's FACTOR copies still fit.
   localparam int unsigned READY_MAX = DEPTH - FACTOR + 1;

   generate
      if ((FACTOR < 1) || (FACTOR > 8) || (DEPTH < FACTOR)) begin : g_bad_cfg
         $error("multiply_tokens: need 1 <= FACTOR <= 8 and DEPTH >= FACTOR");
      end
   endgenerate

   logic [PW-1:0] p_q;
   logic [PW-1:0] p_d;
   logic          overflow_d;
   logic          acc;

   // Backlog and sticky overflow registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q      <= '0;
         overflow <= 1'b0;
      end else begin
         p_q      <= p_d;
         overflow <= overflow_d;
      end
   end

   // Acceptance, output token and next backlog.
   always_comb begin
      a_ready    = 1'b0;
      acc        = 1'b0;
      b          = 1'b0;
      busy       = 1'b0;
      p_d        = p_q;
      overflow_d = overflow;

      a_ready    = (32'(p_q) <= READY_MAX);
      acc        = a & a_ready;
      busy       = (p_q != '0);
      // First copy leaves in the arrival cycle; backlog keeps b high after.
      b          = acc | busy;
      // Never wraps: acceptance guarantees the sum stays within DEPTH.
      p_d        = p_q + (acc ? PW'(FACTOR) : '0) - PW'(b);
      overflow_d = overflow | (a & ~a_ready);
   end

`ifdef MULTIPLY_TOKENS_STATS_EN
   sat_counter #(.W(STAT_W)) u_in_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (acc),
      .count (tokens_in)
   );

   sat_counter #(.W(STAT_W)) u_out_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (b),
      .count (tokens_out)
   );
`endif

endmodule

// File: tb/tb_multiply_tokens.sv
// Self-checking bench for multiply_tokens: five configurations run side by
// side against a token-owed reference model, plus directed scenarios.
module tb_multiply_tokens;

   localparam int N = 5;

   function automatic int unsigned fac(input int i);
      case (i)
         0: return 2;
         1: return 2;
         2: return 3;
         3: return 1;
         default: return 4;
      endcase
   endfunction

   function automatic int unsigned dep(input int i);
      case (i)
         1: return 4;
         4: return 8;
         default: return 15;
      endcase
   endfunction

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] a_v;
   logic [N-1:0] rdy_v;
   logic [N-1:0] b_v;
   logic [N-1:0] busy_v;
   logic [N-1:0] ovf_v;
`ifdef MULTIPLY_TOKENS_STATS_EN
   logic [15:0]  tin  [N];
   logic [15:0]  tout [N];
`endif

   always #5 clk = ~clk;

   generate
      for (genvar g = 0; g < N; g++) begin : g_dut
         multiply_tokens #(.FACTOR(fac(g)), .DEPTH(dep(g))) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .a          (a_v[g]),
            .a_ready    (rdy_v[g]),
            .b          (b_v[g]),
            .busy       (busy_v[g]),
            .overflow   (ovf_v[g])
`ifdef MULTIPLY_TOKENS_STATS_EN
            ,
            .tokens_in  (tin[g]),
            .tokens_out (tout[g])
`endif
         );
      end
   endgenerate

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: number of output copies still owed per instance.
   int owed [N];
   bit movf [N];
   int m_in [N];
   int m_out[N];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_ready(input int i);
      return owed[i] <= int'(dep(i)) - int'(fac(i)) + 1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         owed[i] = 0; movf[i] = 0; m_in[i] = 0; m_out[i] = 0;
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < N; i++) begin
         bit r;
         bit o;
         r = m_ready(i);
         o = (a_v[i] & r) | (owed[i] > 0);
         check($sformatf("b[%0d]", i), 32'(b_v[i]), 32'(o));
         check($sformatf("a_ready[%0d]", i), 32'(rdy_v[i]), 32'(r));
         check($sformatf("busy[%0d]", i), 32'(busy_v[i]), 32'(owed[i] > 0));
         check($sformatf("overflow[%0d]", i), 32'(ovf_v[i]), 32'(movf[i]));
`ifdef MULTIPLY_TOKENS_STATS_EN
         check($sformatf("tokens_in[%0d]", i), 32'(tin[i]), 32'(m_in[i]));
         check($sformatf("tokens_out[%0d]", i), 32'(tout[i]), 32'(m_out[i]));
`endif
      end
   endtask

   // Advance the model across one clock edge using the current inputs.
   task automatic model_edge();
      for (int i = 0; i < N; i++) begin
         bit r;
         bit acc;
         bit o;
         r   = m_ready(i);
         acc = a_v[i] & r;
         o   = acc | (owed[i] > 0);
         if (a_v[i] && !r) movf[i] = 1;
         owed[i] = owed[i] + (acc ? int'(fac(i)) : 0) - (o ? 1 : 0);
         if (acc && m_in[i] < 65535) m_in[i]++;
         if (o && m_out[i] < 65535) m_out[i]++;
      end
   endtask

   // Drive one cycle of input at the falling edge, optionally check, advance model.
   task automatic step(input logic [N-1:0] av, input bit chk);
      @(negedge clk);
      a_v = av;
      #1;
      if (chk) check_all();
      model_edge();
   endtask

   initial begin
      bit s1a [6] = '{1, 0, 1, 1, 0, 0};
      bit s1busy [6] = '{0, 1, 0, 1, 1, 1};
      bit s2rdy [8] = '{1, 1, 1, 1, 0, 1, 0, 1};
      bit s3b [4] = '{1, 1, 1, 0};
      bit s3busy [4] = '{0, 1, 1, 0};
      logic [63:0] pat;
      int dens;

      // Reset state.
      rst_n = 1'b0;
      a_v   = '0;
      model_reset();
      #2;
      check_all();
      check("reset_b", 32'(b_v), 32'd0);
      check("reset_ready", 32'(rdy_v), 32'h1f);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Scenario 1: FACTOR=2, DEPTH=15.
      for (int k = 0; k < 6; k++) begin
         step(N'(s1a[k]), 1);
         check("s1_b", 32'(b_v[0]), 32'd1);
         check("s1_busy", 32'(busy_v[0]), 32'(s1busy[k]));
         check("s1_ready", 32'(rdy_v[0]), 32'd1);
      end
      step('0, 1);
      check("s1_b_idle", 32'(b_v[0]), 32'd0);
`ifdef MULTIPLY_TOKENS_STATS_EN
      check("s1_tokens_in", 32'(tin[0]), 32'd3);
      check("s1_tokens_out", 32'(tout[0]), 32'd6);
`endif

      // Scenario 3: FACTOR=3 single token.
      for (int k = 0; k < 4; k++) begin
         step((k == 0) ? N'(5'b00100) : '0, 1);
         check("s3_b", 32'(b_v[2]), 32'(s3b[k]));
         check("s3_busy", 32'(busy_v[2]), 32'(s3busy[k]));
      end

      // Scenario 2: FACTOR=2, DEPTH=4 held input, then drain.
      for (int k = 0; k < 14; k++) begin
         step((k < 8) ? N'(5'b00010) : '0, 1);
         if (k < 8) check("s2_ready", 32'(rdy_v[1]), 32'(s2rdy[k]));
         check("s2_b", 32'(b_v[1]), 32'(k < 12));
         check("s2_overflow", 32'(ovf_v[1]), 32'(k >= 5));
      end

      // Scenario 4: FACTOR=1 pass-through.
      pat = {$urandom, $urandom};
      for (int k = 0; k < 64; k++) begin
         step(N'({pat[k], 3'b000}), 1);
         check("s4_b_eq_a", 32'(b_v[3]), 32'(pat[k]));
         check("s4_busy", 32'(busy_v[3]), 32'd0);
         check("s4_overflow", 32'(ovf_v[3]), 32'd0);
      end

      // Random traffic on all configurations at several densities.
      for (int k = 0; k < 400; k++) begin
         logic [N-1:0] av;
         case (k / 100)
            0: dens = 20;
            1: dens = 50;
            2: dens = 90;
            default: dens = 60;
         endcase
         for (int i = 0; i < N; i++) av[i] = ($urandom_range(0, 99) < dens);
         step(av, 1);
      end

      // Scenario 5: reset mid-drain with FACTOR=4.
      for (int k = 0; k < 16; k++) step('0, 1);
      step(N'(5'b10000), 1);
      check("s5_first", 32'(b_v[4]), 32'd1);
      @(negedge clk);
      a_v = '0;
      #1;
      check("s5_draining", 32'(b_v[4]), 32'd1);
      check("s5_busy_before", 32'(busy_v[4]), 32'd1);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("s5_b_falls", 32'(b_v[4]), 32'd0);
      check("s5_busy_rst", 32'(busy_v[4]), 32'd0);
      check("s5_overflow_rst", 32'(ovf_v), 32'd0);
      a_v = N'(5'b00001);
      #1;
      check("s5_b_follows_a", 32'(b_v[0]), 32'd1);
      check("s5_ready_rst", 32'(rdy_v), 32'h1f);
      a_v = '0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step('0, 1);
         check("s5_no_tokens", 32'(b_v[4]), 32'd0);
      end

`ifdef MULTIPLY_TOKENS_STATS_EN
      // Saturation of the accepted-token counter on the pass-through instance.
      for (int k = 0; k < 70000; k++) step(N'(5'b01000), 0);
      step('0, 1);
      check("stats_in_sat", 32'(tin[3]), 32'h0000ffff);
      check("stats_out_sat", 32'(tout[3]), 32'h0000ffff);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
